// File: rtl/fifo_sync_param.sv
// fifo_sync_param: single-clock FIFO with a parameterised width and depth,
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
//
// Build option:
//   FIFO_SYNC_FWFT_EN - first-word-fall-through read mode. rd_data shows the
//                       head word whenever the FIFO is non-empty, rd_en acts
//                       as an acknowledge, and rd_data is 0 while empty.
//                       When the macro is undefined, rd_data is a register
//                       that loads the head word on an accepted read (1-cycle
//                       latency) and holds otherwise.
//
// rst_n is asynchronous and active-low; its deassertion is assumed to be
// synchronised to clk outside this block.

module fifo_sync_param #(
  parameter int DATA_W    = 48,
  parameter int ADDR_W    = 5,
  parameter int AFULL_TH  = (1 << ADDR_W) - 4,
  parameter int AEMPTY_TH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic              err_clr,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = 1 << ADDR_W;

  // Thresholds cast once to the count width so the flag compares are exact.
  localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] AFULL_C  = (ADDR_W + 1)'(AFULL_TH);
  localparam logic [ADDR_W:0] AEMPTY_C = (ADDR_W + 1)'(AEMPTY_TH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              wr_acc;
  logic              rd_acc;

  // Accept decisions use the flags as they stand at the start of the cycle.
  // When full, only the read can be taken; when empty, only the write.
  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  // Status flags decode straight from the registered count: no extra latency.
  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AFULL_C);
  assign almost_empty = (count <= AEMPTY_C);

  // Pointer and occupancy update; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values of the others, independent of statement order.
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array: written only on an accepted write.
  always_ff @(posedge clk) begin
    // NOTE: the array deliberately has no reset; clearing count and pointers
    // already makes old contents unreachable, and a reset here would turn
    // the RAM into a bank of resettable flops.
    if (wr_acc) mem[wr_ptr] <= wr_data;
  end

  // Sticky error flags: a new error in the same cycle wins over err_clr.
  // A simultaneous read/write on a full (empty) FIFO is a legal
  // pop-only (push-only) cycle, so it does not raise overflow (underflow).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full && !rd_en) overflow <= 1'b1;
      else if (err_clr)            overflow <= 1'b0;

      if (rd_en && empty && !wr_en) underflow <= 1'b1;
      else if (err_clr)             underflow <= 1'b0;
    end
  end

`ifdef FIFO_SYNC_FWFT_EN
  // Head word is visible combinationally from the array; 0 while empty.
  assign rd_data = empty ? '0 : mem[rd_ptr];
`else
  // Registered read port: loads the head word on an accepted read only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else if (rd_acc) rd_data <= mem[rd_ptr];
  end
`endif

endmodule
